// File: rtl/coin_bank.sv
`default_nettype none
// ============================================================================
// Module      : coin_bank
// Description : Credit accumulator for a coin-operated vending front end.
//               Coin, refund and vend-grant inputs are synchronised and
//               edge-detected; each detected rising edge is one event.
//               Vend deductions apply before same-cycle coin credits, and
//               credit is held within 0..MAXCREDIT. A refund request pays
//               out the whole credit in a single REFUND cycle.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   MAXCREDIT     credit ceiling in cents (legal 30..127)
// Ports
//   clk           system clock, rising edge active
//   rst_n         asynchronous active-low reset
//   coin[2:0]     coin switches: bit0 nickel(5) bit1 dime(10) bit2 quarter(25)
//   ret           refund button (level, asynchronous)
//   vending[3:0]  vend grants: items costing 5/10/15/30 cents
//   money[6:0]    registered credit in cents
//   refund[6:0]   refunded amount, non-zero only while refund_valid=1
//   refund_valid  one-cycle pulse per refund
//   coin_reject   one-cycle pulse when a coin edge is not credited
//   vend_error    one-cycle pulse when a vend edge is not deducted
// ============================================================================
module coin_bank #(
  parameter int MAXCREDIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] coin,
  input  logic       ret,
  input  logic [3:0] vending,
  output logic [6:0] money,
  output logic [6:0] refund,
  output logic       refund_valid,
  output logic       coin_reject,
  output logic       vend_error
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [7:0] C_MAX     = 8'(MAXCREDIT);
  localparam logic [7:0] C_NICKEL  = 8'd5;
  localparam logic [7:0] C_DIME    = 8'd10;
  localparam logic [7:0] C_QUARTER = 8'd25;
  localparam logic [6:0] C_COST0   = 7'd5;
  localparam logic [6:0] C_COST1   = 7'd10;
  localparam logic [6:0] C_COST2   = 7'd15;
  localparam logic [6:0] C_COST3   = 7'd30;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_REFUND = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisation and rising-edge detection
  // All eight asynchronous inputs share one pipeline:
  //   bit layout {ret, vending[3:0], coin[2:0]}
  // r_sync1/r_sync2 form the two-flop synchroniser, r_hist holds the previous
  // synchronised value and r_evt registers the detected rising edge, so an
  // input first sampled on edge k is an event during the cycle after edge k+2
  // and its effect on money/flags appears after edge k+3.
  // --------------------------------------------------------------------------
  logic [7:0] w_raw;
  logic [7:0] r_sync1;
  logic [7:0] r_sync2;
  logic [7:0] r_hist;
  logic [7:0] r_evt;

  assign w_raw = {ret, vending, coin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
      r_evt   <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_evt   <= r_sync2 & ~r_hist;
    end
  end

  logic [2:0] w_coin_ev;
  logic [3:0] w_vend_ev;
  logic       w_ret_ev;

  assign w_coin_ev = r_evt[2:0];
  assign w_vend_ev = r_evt[6:3];
  assign w_ret_ev  = r_evt[7];

  // --------------------------------------------------------------------------
  // Event decoding
  // Only the lowest-index vend is evaluated; any additional simultaneous vend
  // edge is always reported as an error. Only the highest-value coin counts;
  // lower simultaneous coins are silently dropped.
  // --------------------------------------------------------------------------
  logic [6:0] w_vend_cost;
  logic       w_vend_any;
  logic       w_vend_multi;
  logic [7:0] w_coin_val;
  logic       w_coin_any;

  always_comb begin
    w_vend_cost = '0;
    if (w_vend_ev[0]) begin
      w_vend_cost = C_COST0;
    end else if (w_vend_ev[1]) begin
      w_vend_cost = C_COST1;
    end else if (w_vend_ev[2]) begin
      w_vend_cost = C_COST2;
    end else if (w_vend_ev[3]) begin
      w_vend_cost = C_COST3;
    end
  end

  assign w_vend_any   = |w_vend_ev;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_vend_multi = (w_vend_ev & (w_vend_ev - 4'd1)) != 4'd0;

  always_comb begin
    w_coin_val = '0;
    if (w_coin_ev[2]) begin
      w_coin_val = C_QUARTER;
    end else if (w_coin_ev[1]) begin
      w_coin_val = C_DIME;
    end else if (w_coin_ev[0]) begin
      w_coin_val = C_NICKEL;
    end
  end

  assign w_coin_any = |w_coin_ev;

  // --------------------------------------------------------------------------
  // Credit arithmetic for the normal (non-refund) path
  // Deduction first, then the coin is tested against the post-deduction
  // balance. The sum is kept one bit wider so a quarter on top of 127 cannot
  // wrap before the ceiling comparison.
  // --------------------------------------------------------------------------
  logic [6:0] r_money;
  logic [6:0] w_after_vend;
  logic       w_vend_fail;
  logic [7:0] w_sum;
  logic       w_coin_fits;

  always_comb begin
    w_after_vend = r_money;
    w_vend_fail  = 1'b0;
    if (w_vend_any) begin
      if (w_vend_cost <= r_money) begin
        w_after_vend = r_money - w_vend_cost;
      end else begin
        w_vend_fail = 1'b1;
      end
    end
  end

  assign w_sum       = {1'b0, w_after_vend} + w_coin_val;
  assign w_coin_fits = (w_sum <= C_MAX);

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] w_money_nxt;
  logic [6:0] r_refund;
  logic [6:0] w_refund_nxt;
  logic       r_refund_valid;
  logic       w_refund_valid_nxt;
  logic       r_coin_reject;
  logic       w_coin_reject_nxt;
  logic       r_vend_error;
  logic       w_vend_error_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_money        <= '0;
      r_refund       <= '0;
      r_refund_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_vend_error   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_money        <= w_money_nxt;
      r_refund       <= w_refund_nxt;
      r_refund_valid <= w_refund_valid_nxt;
      r_coin_reject  <= w_coin_reject_nxt;
      r_vend_error   <= w_vend_error_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and next registered outputs
  // The refund amount and valid flag are loaded on the edge that enters
  // REFUND, so they are visible for exactly the REFUND cycle. Any coin or
  // vend edge that coincides with a refund request, or arrives during
  // REFUND, leaves money alone and is flagged.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt        = r_state;
    w_money_nxt        = r_money;
    w_refund_nxt       = '0;
    w_refund_valid_nxt = 1'b0;
    w_coin_reject_nxt  = 1'b0;
    w_vend_error_nxt   = 1'b0;

    case (r_state)
      S_REFUND: begin
        // Refund is paid out on this edge; a further refund request is
        // ignored because the balance is already being cleared.
        w_money_nxt       = '0;
        w_state_nxt       = S_IDLE;
        w_coin_reject_nxt = w_coin_any;
        w_vend_error_nxt  = w_vend_any;
      end

      default: begin
        if (w_ret_ev) begin
          w_state_nxt        = S_REFUND;
          w_refund_nxt       = r_money;
          w_refund_valid_nxt = 1'b1;
          w_coin_reject_nxt  = w_coin_any;
          w_vend_error_nxt   = w_vend_any;
        end else begin
          w_vend_error_nxt = w_vend_fail | w_vend_multi;
          if (w_coin_any && w_coin_fits) begin
            w_money_nxt = w_sum[6:0];
          end else begin
            w_money_nxt       = w_after_vend;
            w_coin_reject_nxt = w_coin_any;
          end
          // IDLE is exactly "no credit"; a credited coin moves to CREDIT and
          // a deduction down to zero returns to IDLE.
          if (w_money_nxt == 7'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_CREDIT;
          end
        end
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign money        = r_money;
  assign refund       = r_refund;
  assign refund_valid = r_refund_valid;
  assign coin_reject  = r_coin_reject;
  assign vend_error   = r_vend_error;

endmodule
`default_nettype wire

// File: doc/coin_bank.md
COIN_BANK -- requirements
Module: coin_bank

Interface
REQ-001 Parameter MAXCREDIT, default 100: credit ceiling in cents; legal range 30..127.
REQ-002 Clk  in  1  system clock; all state changes on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 Coin  in  3  level inputs from coin switches; bit0=nickel(5), bit1=dime(10), bit2=quarter(25); asynchronous to Clk.
REQ-005 Return  in  1  level input, refund button; asynchronous to Clk.
REQ-006 Vending  in  4  vend grants from the buy stage; bit0..3 = items costing 5/10/15/30.
REQ-007 Money  out  7  current registered credit in cents; feeds the buy stage.
REQ-008 Refund  out  7  refunded amount; valid only while RefundValid=1, else 0.
REQ-009 RefundValid  out  1  one-cycle pulse per refund.
REQ-010 CoinReject  out  1  one-cycle pulse when a coin edge is not credited.
REQ-011 VendError  out  1  one-cycle pulse when a Vending edge is not deducted.

Function
REQ-012 Coin, Return and Vending SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector; only detected rising edges are events.
REQ-013 An input first sampled high on Clk edge k SHALL produce its event in cycle k+2, with the Money/flag update visible after edge k+3.
REQ-014 Coin priority: when several coin events coincide, only the highest bit SHALL be evaluated; lower ones are ignored with no reject pulse.
REQ-015 Coin credit: if Money(after this cycle's vend deduction) + value <= MAXCREDIT, Money SHALL increase by value; else Money unchanged and CoinReject pulses.
REQ-016 Vend deduction: one Vending event SHALL subtract its cost if cost <= Money; if cost > Money, Money unchanged and VendError pulses.
REQ-017 Several Vending events in one cycle: lowest index SHALL be deducted per REQ-016; VendError SHALL pulse for the others.
REQ-018 Same-cycle vend and coin: deduction SHALL apply first, then coin per REQ-015, both in one cycle.
REQ-019 Money SHALL never exceed MAXCREDIT nor underflow; no wrap-around under any input.
REQ-020 FSM states: IDLE (Money=0), CREDIT (Money>0), REFUND (one cycle).
REQ-021 IDLE->CREDIT when a coin is credited; CREDIT->IDLE when a deduction makes Money 0.
REQ-022 Return event in IDLE or CREDIT SHALL enter REFUND next cycle; in REFUND, Refund=Money, RefundValid=1, then Money=0 and state=IDLE on the following edge.
REQ-023 Return event in IDLE SHALL still produce a REFUND cycle with Refund=0.
REQ-024 Return has priority: coin/vend events in the same cycle as a Return event, or during REFUND, SHALL not change Money; coins pulse CoinReject, vends pulse VendError.
REQ-025 Return events during REFUND SHALL be ignored.
REQ-026 Flags SHALL be registered; no output is combinational from any input.

Reset
REQ-027 While Reset=0: Money=0, Refund=0, RefundValid=0, CoinReject=0, VendError=0, state=IDLE, synchronizer and edge-detector flops=0.
REQ-028 An input held high across Reset release SHALL generate one event after release (edge seen from cleared history); bench must confirm exactly one.
REQ-029 Reset asserted during REFUND SHALL abort it; no RefundValid pulse after release.

Verification
REQ-030 Reset, then nickel, dime, quarter pulses spaced 5 cycles -> Money 5, 15, 40, each update 3 edges after first high sample.
REQ-031 MAXCREDIT=100, Money=90, quarter -> CoinReject one pulse, Money stays 90; then dime -> Money 100.
REQ-032 Money=20, Vending=4'b1010 rises -> Money 10 (item1 deducted), VendError one pulse; then Vending[3] -> VendError, Money 10.
REQ-033 Money=10, Vending[1] and nickel rise together -> Money 5, state CREDIT, no flags.
REQ-034 Money=45, Return and dime together -> next cycle RefundValid=1, Refund=45, CoinReject=1; following cycle Money=0, Refund=0, state IDLE.
REQ-035 Reset pulsed low mid-credit (Money=35) with Coin[2] held high -> Money 0 immediately; after release exactly one quarter credited -> Money 25.
